key_req_latch: RTL and testbench
================================

Name: key_req_latch

Overview:
- Upstream input conditioner for the 4-line priority encoder.
- Synchronises and debounces four raw push-button/switch lines, and detects press (rising) events.
- Latches the pressed set onto request lines y0..y3 and holds them until the consumer acknowledges, so the encoder sees clean, stable one-shot request patterns.

Parameters:
- DB_CYCLES, 16: consecutive stable cycles required before a debounced level changes; legal range 2..2^CNT_W.
- CNT_W, 5: width of each per-line debounce counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- key_in  in  4  raw asynchronous key levels; bit i maps to yi.
- ack  in  1  consumer acknowledge; sampled only in HOLD.
- y0  out  1  latched request, line 0.
- y1  out  1  latched request, line 1.
- y2  out  1  latched request, line 2.
- y3  out  1  latched request, line 3.
- req_valid  out  1  high while y0..y3 carry a pending pattern.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - sync flops, debounced levels db[3:0], counters, y0..y3 and req_valid all go to 0.
  - FSM goes to IDLE.
  - Reset takes priority over all other activity, including mid-HOLD; no pattern survives it.
- Synchroniser: per line, two flops, key_in -> s1 -> s2.
- Debounce, per line, evaluated at each edge:
  - if s2==db: cnt<=0.
  - else if cnt==DB_CYCLES-1: db<=s2, cnt<=0.
  - else: cnt<=cnt+1.
  - Any bounce back to db restarts the count. Counter never wraps.
- Press event: rise[i] = (s2[i]==1 && db[i]==0 && cnt[i]==DB_CYCLES-1), i.e. the edge at which db[i] goes high.
- Latency: key_in high first sampled at edge 0 and held through edge DB_CYCLES -> db high, y/req_valid high after edge DB_CYCLES+1.
- FSM states: IDLE, HOLD, WAIT_REL.
  - IDLE: y=0, req_valid=0.
    - Any rise: y<=rise[3:0] (all simultaneous rises captured together, multi-bit allowed); go to HOLD.
  - HOLD: req_valid=1; y frozen.
    - New rises are ignored.
    - ack=1: y<=0, req_valid<=0.
      - If any db bit is 1 (including one rising that same edge), go to WAIT_REL.
      - Otherwise go to IDLE.
  - WAIT_REL: y=0, req_valid=0; rises are ignored.
    - When db==0, go to IDLE at that edge.
- ack outside HOLD: no effect.
- Release events (db falling) never produce requests.
- y0..y3 are registered outputs, never combinational from key_in.

Optional Feature:
- Macro: KEY_REQ_OVERRUN_EN.
- Defined: adds output port overrun (1 bit, reset 0).
  - Set when any rise occurs in HOLD or WAIT_REL.
  - Cleared at the edge where ack is accepted in HOLD.
  - If ack and a new rise coincide, clear wins.
- Undefined: no overrun port, no overrun flop; dropped presses are silent.

Decomposition:
- Shared package key_req_pkg holds:
  - FSM state encoding: IDLE=2'd0, HOLD=2'd1, WAIT_REL=2'd2.
  - Default constants: DB_CYCLES_DEF=16, CNT_W_DEF=5.
- One natural sub-module: key_debounce_cell.
  - Contents: one line's synchroniser + counter + db flop.
  - Outputs: db and rise.
  - Instantiated four times.
- FSM and output registers stay in key_req_latch.

Test Plan:
- DB_CYCLES=4; key_in=4'b0100 from edge 0, held -> y2=1, req_valid=1 after edge 5; y0/y1/y3 stay 0.
- Glitch: key_in[0] high at edges 0-2 only -> db[0], y0, req_valid stay 0 throughout.
- Simultaneous: key_in=4'b1010 at the same edge -> y3=y1=1 together after edge 5.
  - A later press of key0 during HOLD is ignored; y stays 4'b1010.
- Ack while held: in HOLD with key2 still pressed, ack=1 -> next cycle y=0, req_valid=0, state WAIT_REL.
  - Release key2 -> IDLE 6 edges after key_in falls.
  - No request until a fresh press.
- Reset mid-operation: rst_n=0 for 1 edge while in HOLD with y=4'b0001 -> all outputs 0, IDLE.
  - Key still pressed after reset -> new request after a full debounce (DB_CYCLES+2 cycles).
- With KEY_REQ_OVERRUN_EN: press key1 during HOLD -> overrun=1 after its debounce; ack -> overrun=0 the next cycle.

Source files
------------

// File: rtl/key_req_pkg.sv
// Shared encodings and default constants for the key request latch.
package key_req_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int DB_CYCLES_DEF = 16;
    localparam int CNT_W_DEF     = 5;

endpackage

// File: rtl/key_debounce_cell.sv
// One key line: two-flop synchroniser, stability counter and debounced level,
// plus a one-cycle press indication on the edge where the level goes high.
module key_debounce_cell #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic db,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= key;
            s2 <= s1;
            // Any sample matching the current level restarts the stability count.
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = s2 && !db && (cnt == CNT_MAX);

endmodule

// File: rtl/key_req_latch.sv
// Debounces four key lines and latches press patterns until acknowledged.
// Optional KEY_REQ_OVERRUN_EN adds an overrun flag for presses dropped while busy.
module key_req_latch
    import key_req_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_in,
    input  logic       ack,
    output logic       y0,
    output logic       y1,
    output logic       y2,
    output logic       y3,
`ifdef KEY_REQ_OVERRUN_EN
    output logic       overrun,
`endif
    output logic       req_valid
);

    logic [3:0] db;
    logic [3:0] rise;

    for (genvar i = 0; i < 4; i++) begin : g_line
        key_debounce_cell #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .key  (key_in[i]),
            .db   (db[i]),
            .rise (rise[i])
        );
    end

    state_t     state_q;
    state_t     state_d;
    logic [3:0] y_q;
    logic [3:0] y_d;
    logic       req_valid_q;
    logic       req_valid_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= 4'b0000;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            req_valid_q <= req_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        req_valid_d = req_valid_q;
        unique case (state_q)
            IDLE: begin
                y_d         = 4'b0000;
                req_valid_d = 1'b0;
                if (|rise) begin
                    y_d         = rise;
                    req_valid_d = 1'b1;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (ack) begin
                    y_d         = 4'b0000;
                    req_valid_d = 1'b0;
                    // A key rising on this same edge still counts as held.
                    state_d     = (|(db | rise)) ? WAIT_REL : IDLE;
                end
            end
            WAIT_REL: begin
                y_d         = 4'b0000;
                req_valid_d = 1'b0;
                if (db == 4'b0000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                y_d         = 4'b0000;
                req_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

`ifdef KEY_REQ_OVERRUN_EN
    logic overrun_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (state_q == HOLD && ack) begin
            overrun_q <= 1'b0;
        end else if ((state_q == HOLD || state_q == WAIT_REL) && (|rise)) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun = overrun_q;
`endif

    assign y0        = y_q[0];
    assign y1        = y_q[1];
    assign y2        = y_q[2];
    assign y3        = y_q[3];
    assign req_valid = req_valid_q;

endmodule

// File: tb/tb_key_req_latch.sv
// Directed bench for key_req_latch with a short debounce window (DB_CYCLES=4).
module tb_key_req_latch;
    import key_req_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_in;
    logic       ack;
    logic       y0, y1, y2, y3;
    logic       req_valid;
`ifdef KEY_REQ_OVERRUN_EN
    logic       overrun;
`endif

    int checks;
    int errors;

    key_req_latch #(
        .DB_CYCLES(4),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .ack      (ack),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
`ifdef KEY_REQ_OVERRUN_EN
        .overrun  (overrun),
`endif
        .req_valid(req_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] yv();
        return {y3, y2, y1, y0};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        key_in = 4'b0000;
        ack    = 1'b0;
        tick(2);
        check_eq("reset_y", yv(), 4'b0000);
        check_eq("reset_rv", 4'(req_valid), 4'd1 ^ 4'd1);
        check_eq("reset_state", 4'(dut.state_q), 4'(IDLE));
        rst_n = 1'b1;

        // Single press on key2
        key_in = 4'b0100;
        tick(5);
        check_eq("single_not_yet_rv", 4'(req_valid), 4'd0);
        tick(1);
        check_eq("single_y", yv(), 4'b0100);
        check_eq("single_rv", 4'(req_valid), 4'd1);

        // Ack while key2 still held
        ack = 1'b1;
        tick(1);
        ack    = 1'b0;
        key_in = 4'b0000;
        check_eq("ack_y", yv(), 4'b0000);
        check_eq("ack_rv", 4'(req_valid), 4'd0);
        check_eq("ack_state", 4'(dut.state_q), 4'(WAIT_REL));
        tick(6);
        check_eq("rel_still_wait", 4'(dut.state_q), 4'(WAIT_REL));
        tick(1);
        check_eq("rel_idle", 4'(dut.state_q), 4'(IDLE));
        tick(10);
        check_eq("rel_no_req", 4'(req_valid), 4'd0);

        // Glitch: key0 sampled high on three edges only
        key_in = 4'b0001;
        tick(3);
        key_in = 4'b0000;
        tick(3);
        check_eq("glitch_rv", 4'(req_valid), 4'd0);
        check_eq("glitch_db", dut.db, 4'b0000);
        tick(5);
        check_eq("glitch_y", yv(), 4'b0000);

        // Simultaneous press of key3 and key1, later key0 during HOLD
        key_in = 4'b1010;
        tick(6);
        check_eq("simul_y", yv(), 4'b1010);
        check_eq("simul_rv", 4'(req_valid), 4'd1);
        key_in = 4'b1011;
        tick(8);
        check_eq("hold_ignore_y", yv(), 4'b1010);
`ifdef KEY_REQ_OVERRUN_EN
        check_eq("overrun_set", 4'(overrun), 4'd1);
`endif
        ack = 1'b1;
        tick(1);
        ack    = 1'b0;
        key_in = 4'b0000;
        check_eq("simul_ack_y", yv(), 4'b0000);
`ifdef KEY_REQ_OVERRUN_EN
        check_eq("overrun_clr", 4'(overrun), 4'd0);
`endif
        tick(7);
        check_eq("simul_rel_idle", 4'(dut.state_q), 4'(IDLE));

        // Reset in the middle of HOLD, key kept pressed
        key_in = 4'b0001;
        tick(6);
        check_eq("pre_rst_y", yv(), 4'b0001);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_eq("midrst_y", yv(), 4'b0000);
        check_eq("midrst_rv", 4'(req_valid), 4'd0);
        check_eq("midrst_state", 4'(dut.state_q), 4'(IDLE));
        tick(5);
        check_eq("post_rst_early_rv", 4'(req_valid), 4'd0);
        tick(1);
        check_eq("post_rst_y", yv(), 4'b0001);
        check_eq("post_rst_rv", 4'(req_valid), 4'd1);
        ack = 1'b1;
        tick(1);
        ack    = 1'b0;
        key_in = 4'b0000;
        tick(7);
        check_eq("final_idle", 4'(dut.state_q), 4'(IDLE));

        // Ack outside HOLD has no effect
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        check_eq("idle_ack_rv", 4'(req_valid), 4'd0);
        check_eq("idle_ack_state", 4'(dut.state_q), 4'(IDLE));
`ifdef KEY_REQ_OVERRUN_EN
        check_eq("overrun_end", 4'(overrun), 4'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
